serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/fa_slice.sv | 13 +
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Controller states: IDLE waits for start, RUN processes one bit per clock,
  // DONE is the single result-valid cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_slice.sv
// One-bit full adder slice; purely combinational.
module fa_slice (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x ^ y) & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice sequenced LSB first over WIDTH clocks.
//
// Handshake: start is sampled on every rising edge but only accepted in IDLE;
// a, b and cin are captured on the accepting edge. busy is high for the WIDTH
// cycles of RUN, then done pulses for exactly one cycle with sum/cout/overflow
// valid. start seen in RUN or DONE is dropped, not queued. Results hold until
// the next accepted start.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Current state is kept as a named enum so checkers can bind to it directly.
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  assign last_bit = (cnt == LAST);

  fa_slice u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: capture operands on accept, then shift one bit per RUN cycle.
  // The counter holds on the last bit so it never wraps inside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          if (last_bit) begin
            // carry currently holds the carry into the MSB.
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
